// File: rtl/mem_stage_ctrl_if.sv
// Data-memory request/ack bus between the MEM stage and the data memory.
// The master issues req/we/addr/be/wdata; the slave returns ack and rdata.
interface mem_stage_ctrl_if #(
  parameter int AW = 32
);
  logic          dmem_req;
  logic          dmem_we;
  logic [AW-1:0] dmem_addr;
  logic [3:0]    dmem_be;
  logic [31:0]   dmem_wdata;
  logic          dmem_ack;
  logic [31:0]   dmem_rdata;

  modport master (
    output dmem_req,
    output dmem_we,
    output dmem_addr,
    output dmem_be,
    output dmem_wdata,
    input  dmem_ack,
    input  dmem_rdata
  );

  modport slave (
    input  dmem_req,
    input  dmem_we,
    input  dmem_addr,
    input  dmem_be,
    input  dmem_wdata,
    output dmem_ack,
    output dmem_rdata
  );
endinterface

// File: rtl/mem_stage_ctrl.sv
// MEM stage: turns EX/MEM loads/stores into one req/ack memory access,
// stalls upstream until it ends, and registers the MEM/WB slot.
module mem_stage_ctrl #(
  parameter int TIMEOUT = 16,
  parameter int AW      = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid_in,
  input  logic [3:0]  wb_in,
  input  logic [2:0]  mem_in,
  input  logic [63:0] alu_res_in,
  input  logic [31:0] rt_data_in,
  input  logic [4:0]  dest_in,
  input  logic [1:0]  float_in,
  input  logic        alu_mem_read_in,
  input  logic        alu_mem_write_in,
  input  logic        alu_RegWrite_in,
  output logic        stall_out,
  mem_stage_ctrl_if.master dmem,
  output logic [3:0]  wb_out,
  output logic [31:0] mem_data_out,
  output logic [63:0] alu_res_out,
  output logic [4:0]  dest_out,
  output logic [1:0]  float_out,
  output logic        RegWrite_out,
  output logic        valid_out,
  output logic        mem_err_out
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [0:0] {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;

  logic [AW-1:0] r_addr;
  logic [3:0]    r_be;
  logic [31:0]   r_wdata;
  logic          r_we;
  logic [1:0]    r_lo;
  logic [1:0]    r_size;
  logic          r_uns;

  logic [AW-1:0] w_addr;
  logic [AW-1:0] w_addr_al;
  logic [1:0]    w_size;
  logic [1:0]    w_lo;
  logic          w_start;
  logic          w_mis;
  logic          w_go;
  logic          w_ack;
  logic          w_wait;
  logic          w_tmo;
  logic          w_ok;
  logic          w_fail;
  logic          w_bad;
  logic          w_req;
  logic          w_stall;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_ld;

  assign w_addr    = alu_res_in[AW-1:0];
  assign w_addr_al = {w_addr[AW-1:2], 2'b00};
  assign w_size    = mem_in[1:0];
  assign w_lo      = w_addr[1:0];
  assign w_start   = valid_in & (alu_mem_read_in | alu_mem_write_in);
  assign w_go      = w_start & ~w_mis;
  assign w_ack     = dmem.dmem_ack;
  assign w_wait    = (r_state == S_WAIT);
  assign w_tmo     = w_wait & (r_cnt == CW'(TIMEOUT - 1));
  assign w_ok      = w_wait & w_ack;
  assign w_fail    = w_tmo & ~w_ack;
  assign w_bad     = (r_state == S_IDLE) & w_start & w_mis;

  always_comb begin
    w_mis = 1'b1;
    unique case (w_size)
      2'b00:   w_mis = 1'b0;
      2'b01:   w_mis = w_lo[0];
      2'b10:   w_mis = |w_lo;
      default: w_mis = 1'b1;
    endcase
  end

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = rt_data_in;
    unique case (w_size)
      2'b00: begin
        w_be    = 4'b0001 << w_lo;
        w_wdata = {4{rt_data_in[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << w_lo;
        w_wdata = {2{rt_data_in[15:0]}};
      end
      2'b10: begin
        w_be    = 4'b1111;
        w_wdata = rt_data_in;
      end
      default: begin
        w_be    = 4'b0000;
        w_wdata = rt_data_in;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_stall     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_go) begin
          w_req       = 1'b1;
          w_stall     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A late ack on the timeout cycle still wins.
        w_req   = w_ack | ~w_tmo;
        w_stall = ~w_ack & ~w_tmo;
        if (w_ack | w_tmo) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign dmem.dmem_req   = w_req & rst_n;
  assign stall_out       = w_stall & rst_n;
  assign dmem.dmem_addr  = w_wait ? r_addr  : w_addr_al;
  assign dmem.dmem_be    = w_wait ? r_be    : w_be;
  assign dmem.dmem_wdata = w_wait ? r_wdata : w_wdata;
  assign dmem.dmem_we    = w_wait ? r_we    : alu_mem_write_in;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_wait ? r_cnt + 1'b1 : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_we    <= 1'b0;
      r_lo    <= '0;
      r_size  <= '0;
      r_uns   <= 1'b0;
    end else if ((r_state == S_IDLE) && w_go) begin
      r_addr  <= w_addr_al;
      r_be    <= w_be;
      r_wdata <= w_wdata;
      r_we    <= alu_mem_write_in;
      r_lo    <= w_lo;
      r_size  <= w_size;
      r_uns   <= mem_in[2];
    end
  end

  always_comb begin
    w_byte = dmem.dmem_rdata[7:0];
    unique case (r_lo)
      2'd0: w_byte = dmem.dmem_rdata[7:0];
      2'd1: w_byte = dmem.dmem_rdata[15:8];
      2'd2: w_byte = dmem.dmem_rdata[23:16];
      2'd3: w_byte = dmem.dmem_rdata[31:24];
      default: w_byte = dmem.dmem_rdata[7:0];
    endcase
    w_half = r_lo[1] ? dmem.dmem_rdata[31:16]
                     : dmem.dmem_rdata[15:0];
    w_ld = dmem.dmem_rdata;
    unique case (r_size)
      2'b00: w_ld = r_uns ? {24'b0, w_byte}
                          : {{24{w_byte[7]}}, w_byte};
      2'b01: w_ld = r_uns ? {16'b0, w_half}
                          : {{16{w_half[15]}}, w_half};
      default: w_ld = dmem.dmem_rdata;
    endcase
    if (r_we) begin
      w_ld = 32'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_out       <= '0;
      mem_data_out <= '0;
      alu_res_out  <= '0;
      dest_out     <= '0;
      float_out    <= '0;
      RegWrite_out <= 1'b0;
      valid_out    <= 1'b0;
      mem_err_out  <= 1'b0;
    end else if (w_stall) begin
      valid_out <= 1'b0;
    end else begin
      wb_out      <= wb_in;
      alu_res_out <= alu_res_in;
      dest_out    <= dest_in;
      float_out   <= float_in;
      valid_out   <= valid_in;
      unique case (1'b1)
        w_ok: begin
          mem_data_out <= w_ld;
          mem_err_out  <= 1'b0;
          RegWrite_out <= alu_RegWrite_in;
        end
        w_fail, w_bad: begin
          mem_data_out <= 32'b0;
          mem_err_out  <= 1'b1;
          RegWrite_out <= 1'b0;
        end
        default: begin
          mem_data_out <= 32'b0;
          mem_err_out  <= 1'b0;
          RegWrite_out <= alu_RegWrite_in;
        end
      endcase
    end
  end

endmodule
